// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - default widths (address, data, grant counter)
//   - FSM state encodings (IDLE / ISSUE / WAIT)
//   - requester port ids (0 = processor, 1 = loader/DMA)
//   - small helper for the round-robin tie break
// No ports; imported by mem_arbiter and rr_arb2.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DEF_AW    = 12;
    localparam int DEF_DW    = 32;
    localparam int DEF_CNT_W = 16;
    localparam int NUM_PORTS = 2;

    // FSM encodings kept as plain constants so older code can compare against them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DMA = 1'b1;

    // With only two requesters "the other one" is a simple inversion.
    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational 2-way arbiter pick.
// Parameters:
//   FIXED_PRI  0 = round-robin (tie goes to the port that was not granted last)
//              1 = port 0 always wins a tie
// Ports:
//   req0, req1   in   requests from port 0 / port 1
//   last         in   port granted most recently
//   grant_valid  out  at least one request present
//   winner       out  selected port id (meaningful only when grant_valid=1)
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last,
    output logic     grant_valid,
    output port_id_t winner
);

    always_comb begin
        grant_valid = req0 | req1;
        winner      = PORT_CPU;
        if (req0 && req1) begin
            winner = (FIXED_PRI != 0) ? PORT_CPU : other_port(last);
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between a processor (port 0) and a
// loader/DMA engine (port 1). One transaction is in flight at a time:
//   IDLE -> ISSUE -> IDLE        (write)
//   IDLE -> ISSUE -> WAIT -> IDLE (read)
// Requests are only looked at in IDLE. All outputs come straight from registers.
// Parameters:
//   AW, DW      address / data width
//   FIXED_PRI   0 = round-robin, 1 = port 0 wins ties
//   CNT_W       width of the saturating per-port grant counters
// Ports (N = 0,1):
//   clk, rst_n                clock, asynchronous active-low reset
//   pN_req/we/addr/wdata      request; fields held stable until pN_gnt
//   pN_gnt                    one-cycle pulse, request accepted (ISSUE cycle)
//   pN_rvalid, pN_rdata       one-cycle read-data pulse; rdata held until next read
//   pN_grant_cnt              grants to port N, saturating at all-ones
//   mem_reading/address/wdata to memory; mem_reading=0 only in a write ISSUE
//   mem_rdata                 from memory, registered one cycle after a read edge
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int FIXED_PRI = 0,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [AW-1:0]    p0_addr,
    input  logic [DW-1:0]    p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [DW-1:0]    p0_rdata,
    output logic [CNT_W-1:0] p0_grant_cnt,

    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [AW-1:0]    p1_addr,
    input  logic [DW-1:0]    p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [DW-1:0]    p1_rdata,
    output logic [CNT_W-1:0] p1_grant_cnt,

    output logic             mem_reading,
    output logic [AW-1:0]    mem_address,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata
);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    port_id_t      owner_reg;
    port_id_t      last_reg;
    logic          we_reg;
    logic          mem_reading_reg;
    logic [AW-1:0] mem_address_reg;
    logic [DW-1:0] mem_wdata_reg;

    logic          grant_valid;
    port_id_t      winner;
    logic          grant_now;
    logic          read_capture;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [NUM_PORTS-1:0] gnt_vec;
    logic [NUM_PORTS-1:0] rvalid_vec;
    logic [DW-1:0]        rdata_arr [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_arr   [NUM_PORTS];

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req0        (p0_req),
        .req1        (p1_req),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    assign grant_now    = (state_reg == ST_IDLE) && grant_valid;
    // WAIT is the cycle in which the memory's registered output holds our word.
    assign read_capture = (state_reg == ST_WAIT);

    assign sel_we    = (winner == PORT_DMA) ? p1_we    : p0_we;
    assign sel_addr  = (winner == PORT_DMA) ? p1_addr  : p0_addr;
    assign sel_wdata = (winner == PORT_DMA) ? p1_wdata : p0_wdata;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = we_reg ? ST_IDLE : ST_WAIT;
            ST_WAIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The memory-side registers are loaded on the grant edge so that the
    // ISSUE cycle already presents address/data/direction to the memory.
    // mem_reading falls back to 1 on every other edge, so the memory can
    // only be written during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= PORT_CPU;
            last_reg        <= PORT_DMA;
            we_reg          <= 1'b0;
            mem_reading_reg <= 1'b1;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            mem_reading_reg <= 1'b1;
            if (grant_now) begin
                owner_reg       <= winner;
                last_reg        <= winner;
                we_reg          <= sel_we;
                mem_address_reg <= sel_addr;
                mem_wdata_reg   <= sel_wdata;
                mem_reading_reg <= ~sel_we;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam port_id_t ID = port_id_t'(gi);

            logic             gnt_reg;
            logic             rvalid_reg;
            logic [DW-1:0]    rdata_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             mine_grant;
            logic             mine_read;

            assign mine_grant = grant_now && (winner == ID);
            assign mine_read  = read_capture && (owner_reg == ID);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gnt_reg    <= 1'b0;
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                    cnt_reg    <= '0;
                end else begin
                    gnt_reg    <= mine_grant;
                    rvalid_reg <= mine_read;
                    if (mine_read) begin
                        rdata_reg <= mem_rdata;
                    end
                    if (mine_grant && (cnt_reg != {CNT_W{1'b1}})) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign gnt_vec[gi]    = gnt_reg;
            assign rvalid_vec[gi] = rvalid_reg;
            assign rdata_arr[gi]  = rdata_reg;
            assign cnt_arr[gi]    = cnt_reg;
        end
    endgenerate

    assign p0_gnt       = gnt_vec[0];
    assign p0_rvalid    = rvalid_vec[0];
    assign p0_rdata     = rdata_arr[0];
    assign p0_grant_cnt = cnt_arr[0];

    assign p1_gnt       = gnt_vec[1];
    assign p1_rvalid    = rvalid_vec[1];
    assign p1_rdata     = rdata_arr[1];
    assign p1_grant_cnt = cnt_arr[1];

    assign mem_reading  = mem_reading_reg;
    assign mem_address  = mem_address_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances on one clock:
//   A: round-robin, 16-bit counters (main functional checks)
//   B: fixed priority, 4-bit counters (starvation and counter saturation)
// Stimulus pushes expected grants / read data into queues; negedge monitors pop
// and compare whenever a DUT presents gnt or rvalid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mem_clr;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A signals ----------------
    logic        a_p0_req, a_p0_we, a_p1_req, a_p1_we;
    logic [11:0] a_p0_addr, a_p1_addr;
    logic [31:0] a_p0_wdata, a_p1_wdata;
    logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid;
    logic [31:0] a_p0_rdata, a_p1_rdata;
    logic [15:0] a_p0_grant_cnt, a_p1_grant_cnt;
    logic        a_mem_reading;
    logic [11:0] a_mem_address;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    // ---------------- instance B signals ----------------
    logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [11:0] b_p0_addr, b_p1_addr;
    logic [31:0] b_p0_wdata, b_p1_wdata;
    logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic [3:0]  b_p0_grant_cnt, b_p1_grant_cnt;
    logic        b_mem_reading;
    logic [11:0] b_mem_address;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.AW(12), .DW(32), .FIXED_PRI(0), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata), .p0_grant_cnt(a_p0_grant_cnt),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata), .p1_grant_cnt(a_p1_grant_cnt),
        .mem_reading(a_mem_reading), .mem_address(a_mem_address), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.AW(12), .DW(32), .FIXED_PRI(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_grant_cnt(b_p0_grant_cnt),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_grant_cnt(b_p1_grant_cnt),
        .mem_reading(b_mem_reading), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // ---------------- memory models (registered read) ----------------
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem_a[i] <= '0;
        end else if (!a_mem_reading) begin
            mem_a[a_mem_address] <= a_mem_wdata;
        end
        a_mem_rdata <= mem_a[a_mem_address];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem_b[i] <= '0;
        end else if (!b_mem_reading) begin
            mem_b[b_mem_address] <= b_mem_wdata;
        end
        b_mem_rdata <= mem_b[b_mem_address];
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", what);
    endtask

    // ---------------- scoreboard queues ----------------
    int          exp_gnt_a [$];
    int          exp_gnt_b [$];
    logic [31:0] exp_rd_a0 [$];
    logic [31:0] exp_rd_a1 [$];
    int          gnt_cyc_a [2];

    always @(negedge clk) begin : mon_a
        int          got;
        int          want;
        logic [31:0] e;
        if (rst_n) begin
            if (a_p0_gnt || a_p1_gnt) begin
                got = a_p1_gnt ? 1 : 0;
                check("a_gnt_onehot", 32'(a_p0_gnt & a_p1_gnt), 32'd0);
                gnt_cyc_a[got] = cyc;
                $display("[%0d] A grant port %0d", cyc, got);
                if (exp_gnt_a.size() == 0) begin
                    flag($sformatf("a_unexpected_gnt: port %0d granted, required no grant", got));
                end else begin
                    want = exp_gnt_a.pop_front();
                    check("a_gnt_port", 32'(got), 32'(want));
                end
            end
            if (!a_mem_reading) begin
                check("a_write_only_in_issue", 32'(a_p0_gnt | a_p1_gnt), 32'd1);
            end
            if (a_p0_rvalid) begin
                $display("[%0d] A port 0 read data 0x%08h", cyc, a_p0_rdata);
                if (exp_rd_a0.size() == 0) begin
                    flag($sformatf("a_p0_unexpected_rvalid: data 0x%08h, required no rvalid", a_p0_rdata));
                end else begin
                    e = exp_rd_a0.pop_front();
                    check("a_p0_rdata", a_p0_rdata, e);
                    check("a_p0_rvalid_latency", 32'(cyc - gnt_cyc_a[0]), 32'd2);
                end
            end
            if (a_p1_rvalid) begin
                $display("[%0d] A port 1 read data 0x%08h", cyc, a_p1_rdata);
                if (exp_rd_a1.size() == 0) begin
                    flag($sformatf("a_p1_unexpected_rvalid: data 0x%08h, required no rvalid", a_p1_rdata));
                end else begin
                    e = exp_rd_a1.pop_front();
                    check("a_p1_rdata", a_p1_rdata, e);
                    check("a_p1_rvalid_latency", 32'(cyc - gnt_cyc_a[1]), 32'd2);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int got;
        int want;
        if (rst_n) begin
            if (b_p0_gnt || b_p1_gnt) begin
                got = b_p1_gnt ? 1 : 0;
                $display("[%0d] B grant port %0d", cyc, got);
                if (exp_gnt_b.size() == 0) begin
                    flag($sformatf("b_unexpected_gnt: port %0d granted, required no grant", got));
                end else begin
                    want = exp_gnt_b.pop_front();
                    check("b_gnt_port", 32'(got), 32'(want));
                end
            end
            if (!b_mem_reading) begin
                check("b_write_only_in_issue", 32'(b_p0_gnt | b_p1_gnt), 32'd1);
            end
            if (b_p0_rvalid || b_p1_rvalid) begin
                flag("b_unexpected_rvalid: rvalid seen, required none (writes only)");
            end
        end
    end

    // ---------------- stimulus helpers (instance A) ----------------
    task automatic a_drive(input int port, input logic req, input logic we,
                           input logic [11:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            a_p0_req = req; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd;
        end else begin
            a_p1_req = req; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd;
        end
    endtask

    task automatic a_wait_gnt(input int port, output int waited);
        logic seen;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 64) begin
            @(posedge clk); #1;
            waited++;
            seen = (port == 0) ? a_p0_gnt : a_p1_gnt;
        end
        if (!seen) flag($sformatf("a_wait_gnt_p%0d: no grant within %0d cycles, required grant", port, waited));
    endtask

    task automatic a_txn(input int port, input logic we, input logic [11:0] addr,
                         input logic [31:0] wd, output int waited);
        a_drive(port, 1'b1, we, addr, wd);
        a_wait_gnt(port, waited);
        a_drive(port, 1'b0, we, addr, wd);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_gnt_a.size() + exp_gnt_b.size() + exp_rd_a0.size() + exp_rd_a1.size()) != 0
               && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int ng;
        int n;

        rst_n   = 1'b0;
        mem_clr = 1'b1;
        a_drive(0, 1'b0, 1'b0, 12'h000, 32'h0);
        a_drive(1, 1'b0, 1'b0, 12'h000, 32'h0);
        b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_addr = '0; b_p1_wdata = '0;

        // Reset held for 5 cycles.
        repeat (5) @(posedge clk);
        #1;
        check("rst_a_p0_gnt",      32'(a_p0_gnt),       32'd0);
        check("rst_a_p1_gnt",      32'(a_p1_gnt),       32'd0);
        check("rst_a_p0_rvalid",   32'(a_p0_rvalid),    32'd0);
        check("rst_a_p1_rvalid",   32'(a_p1_rvalid),    32'd0);
        check("rst_a_mem_reading", 32'(a_mem_reading),  32'd1);
        check("rst_a_mem_address", 32'(a_mem_address),  32'd0);
        check("rst_a_p0_cnt",      32'(a_p0_grant_cnt), 32'd0);
        check("rst_a_p1_cnt",      32'(a_p1_grant_cnt), 32'd0);
        check("rst_a_p0_rdata",    a_p0_rdata,          32'd0);
        check("rst_b_mem_reading", 32'(b_mem_reading),  32'd1);
        check("rst_b_p0_cnt",      32'(b_p0_grant_cnt), 32'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        // Port 0 write then read back 0x010; p1 pulses req while busy and drops it.
        exp_gnt_a.push_back(0);
        a_txn(0, 1'b1, 12'h010, 32'hDEADBEEF, w);
        check("a_idle_gnt_latency", 32'(w), 32'd1);
        exp_gnt_a.push_back(0);
        exp_rd_a0.push_back(32'hDEADBEEF);
        a_txn(0, 1'b0, 12'h010, 32'h0, w);
        a_drive(1, 1'b1, 1'b1, 12'h123, 32'h0BADF00D);
        @(posedge clk); #1;
        a_drive(1, 1'b0, 1'b1, 12'h123, 32'h0BADF00D);
        drain();
        check("a_p0_cnt_after_wr_rd", 32'(a_p0_grant_cnt), 32'd2);
        check("a_p1_cnt_quiet",       32'(a_p1_grant_cnt), 32'd0);
        check("a_mem_0x123_untouched", mem_a[12'h123],     32'd0);

        // Port 1 writes 0xFFF, then both ports hold reads for 6 round-robin grants.
        // Last grant is port 1, so the first tie goes to port 0 (reading 0xFFF).
        exp_gnt_a.push_back(1);
        a_txn(1, 1'b1, 12'hFFF, 32'h12345678, w);
        for (int i = 0; i < 3; i++) begin
            exp_gnt_a.push_back(0);
            exp_gnt_a.push_back(1);
            exp_rd_a0.push_back(32'h12345678);
            exp_rd_a1.push_back(32'hDEADBEEF);
        end
        a_drive(0, 1'b1, 1'b0, 12'hFFF, 32'h0);
        a_drive(1, 1'b1, 1'b0, 12'h010, 32'h0);
        ng = 0;
        n  = 0;
        while (ng < 6 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (a_p0_gnt || a_p1_gnt) ng++;
        end
        a_drive(0, 1'b0, 1'b0, 12'hFFF, 32'h0);
        a_drive(1, 1'b0, 1'b0, 12'h010, 32'h0);
        check("a_rr_grants_seen", 32'(ng), 32'd6);
        drain();
        check("a_p0_cnt_after_rr", 32'(a_p0_grant_cnt), 32'd5);
        check("a_p1_cnt_after_rr", 32'(a_p1_grant_cnt), 32'd4);
        check("a_mem_0x010",       mem_a[12'h010],      32'hDEADBEEF);
        check("a_mem_0xFFF",       mem_a[12'hFFF],      32'h12345678);

        // Reset asserted during WAIT of a port 0 read: no rvalid may follow.
        exp_gnt_a.push_back(0);
        a_txn(0, 1'b0, 12'h010, 32'h0, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("a_mem_reading_in_reset", 32'(a_mem_reading),  32'd1);
        check("a_p0_cnt_in_reset",      32'(a_p0_grant_cnt), 32'd0);
        check("a_p0_rdata_in_reset",    a_p0_rdata,          32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First tie after reset goes to port 0, then port 1.
        exp_gnt_a.push_back(0);
        exp_gnt_a.push_back(1);
        exp_rd_a0.push_back(32'hDEADBEEF);
        exp_rd_a1.push_back(32'h12345678);
        a_drive(1, 1'b1, 1'b0, 12'hFFF, 32'h0);
        a_txn(0, 1'b0, 12'h010, 32'h0, w);
        a_wait_gnt(1, w);
        a_drive(1, 1'b0, 1'b0, 12'hFFF, 32'h0);
        drain();
        check("a_p0_cnt_post_reset", 32'(a_p0_grant_cnt), 32'd1);
        check("a_p1_cnt_post_reset", 32'(a_p1_grant_cnt), 32'd1);

        // Instance B: fixed priority, both ports held writing, 20 grants.
        repeat (20) exp_gnt_b.push_back(0);
        b_p0_we = 1'b1; b_p0_addr = 12'h001; b_p0_wdata = 32'hA5A5A5A5;
        b_p1_we = 1'b1; b_p1_addr = 12'h002; b_p1_wdata = 32'h5A5A5A5A;
        b_p0_req = 1'b1;
        b_p1_req = 1'b1;
        ng = 0;
        n  = 0;
        while (ng < 20 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (b_p0_gnt || b_p1_gnt) ng++;
        end
        b_p0_req = 1'b0;
        b_p1_req = 1'b0;
        check("b_grants_seen", 32'(ng), 32'd20);
        drain();
        check("b_p0_cnt_saturated", 32'(b_p0_grant_cnt), 32'd15);
        check("b_p1_cnt_starved",   32'(b_p1_grant_cnt), 32'd0);
        check("b_mem_0x001",        mem_b[12'h001],      32'hA5A5A5A5);
        check("b_mem_0x002_unused", mem_b[12'h002],      32'd0);
        check("b_p1_rdata_quiet",   b_p1_rdata,          32'd0);
        check("b_p0_rdata_quiet",   b_p0_rdata,          32'd0);

        check("pending_expectations",
              32'(exp_gnt_a.size() + exp_gnt_b.size() + exp_rd_a0.size() + exp_rd_a1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
